// File: rtl/synthesizer_nco_if.sv
// Sample-request and video-output bundle between the timing logic, the NCO
// video generator and the DAC path.
interface synthesizer_nco_if #(
    parameter int OUT_W    = 8,
    parameter int PHASE_W  = 16,
    parameter int COLOUR_W = 6
);
    logic [PHASE_W-1:0]  freq_word;
    logic                phase_sync;
    logic                in_valid;
    logic [1:0]          mode;
    logic [COLOUR_W-1:0] colourNum;
    logic [OUT_W-1:0]    blank_level;
    logic [7:0]          burst_amp;
    logic                out_valid;
    logic [OUT_W-1:0]    video;
    logic                sat;

    modport master (
        output freq_word, phase_sync, in_valid, mode, colourNum, blank_level, burst_amp,
        input  out_valid, video, sat
    );

    modport slave (
        input  freq_word, phase_sync, in_valid, mode, colourNum, blank_level, burst_amp,
        output out_valid, video, sat
    );
endinterface

// File: rtl/synthesizer_nco.sv
// Composite video sample generator: free-running subcarrier NCO, colour/sine
// lookups, signed modulation and clamped DC offset in a fixed 4-stage pipeline.
module synthesizer_nco #(
    parameter int                OUT_W       = 8,
    parameter int                PHASE_W     = 16,
    parameter int                LUT_AW      = 8,
    parameter int                COLOUR_W    = 6,
    parameter int                SHIFT       = 7,
    parameter logic [LUT_AW-1:0] BURST_PHASE = 'h80
) (
    input logic              clk,
    input logic              reset,
    synthesizer_nco_if.slave bus
);
    localparam logic [1:0] MODE_COLOUR = 2'b00;
    localparam logic [1:0] MODE_BURST  = 2'b10;

    // Quarter-wave sine magnitudes, round(127*sin(k*pi/128)) for k = 0..64.
    localparam int QSIN [0:64] = '{
          0,   3,   6,   9,  12,  16,  19,  22,  25,  28,
         31,  34,  37,  40,  43,  46,  49,  51,  54,  57,
         60,  63,  65,  68,  71,  73,  76,  78,  81,  83,
         85,  88,  90,  92,  94,  96,  98, 100, 102, 104,
        106, 107, 109, 111, 112, 113, 115, 116, 117, 118,
        120, 121, 122, 122, 123, 124, 125, 125, 126, 126,
        126, 127, 127, 127, 127
    };

    function automatic logic signed [7:0] sine_rom(input logic [LUT_AW-1:0] a);
        logic [7:0] a8;
        logic [6:0] idx;
        logic [7:0] mag;
        a8  = 8'(({a, 8'h00}) >> LUT_AW);
        idx = a8[6] ? (7'd64 - {1'b0, a8[5:0]}) : {1'b0, a8[5:0]};
        mag = 8'(QSIN[idx]);
        return a8[7] ? -mag : mag;
    endfunction

    // Colour palette: hue steps by 4 LUT codes, amplitude falls and DC rises with index.
    function automatic logic [LUT_AW-1:0] pha_rom(input logic [COLOUR_W-1:0] c);
        return LUT_AW'({c, 2'b00});
    endfunction

    function automatic logic signed [7:0] amp_rom(input logic [COLOUR_W-1:0] c);
        return 8'd127 - 8'({c, 2'b00});
    endfunction

    function automatic logic [OUT_W-1:0] offset_rom(input logic [COLOUR_W-1:0] c);
        return OUT_W'({c, 2'b00});
    endfunction

    logic [PHASE_W-1:0]      acc;
    logic                    v1, v2, v3;
    logic [LUT_AW-1:0]       ph1, poff1;
    logic signed [7:0]       amp1, amp2, sine2;
    logic [OUT_W-1:0]        off1, off2, off3;
    logic                    blank1, blank2, blank3;
    logic signed [15:0]      prod3;
    logic signed [OUT_W+1:0] sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc           <= '0;
            v1            <= 1'b0;
            v2            <= 1'b0;
            v3            <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.video     <= '0;
            bus.sat       <= 1'b0;
        end else begin
            acc <= bus.phase_sync ? '0 : acc + bus.freq_word;
            v1  <= bus.in_valid;
            v2  <= v1;
            v3  <= v2;
            bus.out_valid <= v3;
            if (v3) begin
                if (blank3) begin
                    bus.video <= off3;
                    bus.sat   <= 1'b0;
                end else if (sum[OUT_W+1]) begin
                    bus.video <= '0;
                    bus.sat   <= 1'b1;
                end else if (sum[OUT_W]) begin
                    bus.video <= '1;
                    bus.sat   <= 1'b1;
                end else begin
                    bus.video <= sum[OUT_W-1:0];
                    bus.sat   <= 1'b0;
                end
            end
        end
    end

    // Datapath stages carry no reset; only the valid bits decide what emerges.
    always_ff @(posedge clk) begin
        ph1 <= acc[PHASE_W-1 -: LUT_AW];
        case (bus.mode)
            MODE_COLOUR: begin
                poff1  <= pha_rom(bus.colourNum);
                amp1   <= amp_rom(bus.colourNum);
                off1   <= offset_rom(bus.colourNum);
                blank1 <= 1'b0;
            end
            MODE_BURST: begin
                poff1  <= BURST_PHASE;
                amp1   <= bus.burst_amp;
                off1   <= bus.blank_level;
                blank1 <= 1'b0;
            end
            default: begin
                poff1  <= BURST_PHASE;
                amp1   <= '0;
                off1   <= bus.blank_level;
                blank1 <= 1'b1;
            end
        endcase

        sine2  <= sine_rom(ph1 + poff1);
        amp2   <= amp1;
        off2   <= off1;
        blank2 <= blank1;

        prod3  <= 16'(amp2) * 16'(sine2);
        off3   <= off2;
        blank3 <= blank2;
    end

    always_comb begin
        sum = (OUT_W+2)'(prod3 >>> SHIFT) + $signed({2'b00, off3});
    end
endmodule
